uart_rx_sampler: RTL and testbench

- UART receiver. Consumes the single-cycle `tick` from a fractional-N baud generator instance and drives that generator's `en` and `align` inputs.
- Start-edge alignment makes every tick land at mid-bit.
- Deframes 8N1 by default; optional parity.
- Delivers each received word through a one-entry valid/ready holding register, with frame, parity and overrun flags.
- Sits between the pad-side `rx` line and the command/data-path logic.

---
 rtl/uart_rx_sampler.sv | 111 +++++++++++
 tb/tb_uart_rx_sampler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART receiver driven by an external mid-bit baud tick.
// Realigns the baud generator on each start edge; delivers words through a one-entry valid/ready register.
module uart_rx_sampler #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 baud_tick,
   output logic                 baud_en,
   output logic                 baud_align,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int CW = $clog2(DATA_BITS);
   state_t                 r_state, w_state_n;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev, r_perr, w_perr_n;
   logic                   w_rx_s, w_fall, w_en_n, w_align_n, w_done;
   logic [CW-1:0]          r_cnt, w_cnt_n;
   logic [DATA_BITS-1:0]   r_shift, w_shift_n;

   assign w_rx_s = r_sync[SYNC_STAGES-1];
   assign w_fall = r_prev & ~w_rx_s;
   assign busy   = r_state != IDLE;

   always_comb begin
      w_state_n = r_state;
      w_en_n    = baud_en;
      w_align_n = 1'b0;
      w_cnt_n   = r_cnt;
      w_shift_n = r_shift;
      w_perr_n  = r_perr;
      w_done    = 1'b0;
      case (r_state)
         IDLE: if (w_fall) begin
            w_state_n = START;
            w_en_n    = 1'b1;
            w_align_n = 1'b1;
            w_cnt_n   = '0;
         end
         START: if (baud_tick) begin
            w_state_n = w_rx_s ? IDLE : DATA;
            w_en_n    = ~w_rx_s;
         end
         DATA: if (baud_tick) begin
            w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_cnt_n   = r_cnt + 1'b1;
            if (r_cnt == CW'(DATA_BITS - 1)) w_state_n = (PARITY_EN != 0) ? PARITY : STOP;
         end
         PARITY: if (baud_tick) begin
            w_perr_n  = ^r_shift ^ w_rx_s ^ 1'(PARITY_ODD);
            w_state_n = STOP;
         end
         STOP: if (baud_tick) begin
            w_en_n    = 1'b0;
            w_done    = 1'b1;
            w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync     <= '1;
         r_prev     <= 1'b1;
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         baud_en    <= 1'b0;
         baud_align <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
         r_prev     <= w_rx_s;
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_shift    <= w_shift_n;
         r_perr     <= w_perr_n;
         baud_en    <= w_en_n;
         baud_align <= w_align_n;
         overrun    <= 1'b0;
         // a completing frame may replace the held word only if it is being accepted this cycle
         if (w_done && (!rx_valid || rx_ready)) begin
            rx_data    <= r_shift;
            frame_err  <= ~w_rx_s;
            parity_err <= r_perr;
            rx_valid   <= 1'b1;
         end else if (w_done) begin
            overrun <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed vector bench for uart_rx_sampler, one 8N1 and one 8E1 instance.
// A behavioural baud generator per instance gives 16 clk/bit with the first tick at half period.
module tb_uart_rx_sampler;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0;
   logic       tick0, tick1, en0, en1, al0, al1, v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, bz0, bz1;
   logic [7:0] d0, d1;
   logic [3:0] bc0 = 4'd0, bc1 = 4'd0;

   uart_rx_sampler dut0 (
      .clk(clk), .rst_n(rst_n), .rx(rx0), .baud_tick(tick0), .baud_en(en0), .baud_align(al0),
      .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0),
      .overrun(ov0), .busy(bz0));

   uart_rx_sampler #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .rx(rx1), .baud_tick(tick1), .baud_en(en1), .baud_align(al1),
      .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1),
      .overrun(ov1), .busy(bz1));

   always @(posedge clk) bc0 <= (!en0 || al0) ? 4'd7 : bc0 - 4'd1;
   always @(posedge clk) bc1 <= (!en1 || al1) ? 4'd7 : bc1 - 4'd1;
   assign tick0 = en0 && !al0 && bc0 == 4'd0;
   assign tick1 = en1 && !al1 && bc1 == 4'd0;

   logic       sel = 1'b0;
   logic       sv, sfe, spe, sbz;
   logic [7:0] sd;
   assign sv  = sel ? v1  : v0;
   assign sd  = sel ? d1  : d0;
   assign sfe = sel ? fe1 : fe0;
   assign spe = sel ? pe1 : pe0;
   assign sbz = sel ? bz1 : bz0;

   logic       clr = 1'b0, vq0 = 1'b0;
   int         cyc = 0, ac0 = 0, ac1 = 0, ov_n = 0, tk0 = 0, lt0 = 0, rc0 = 0, cap_n = 0;
   logic [7:0] cap [4];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      vq0 <= v0;
      if (tick0) lt0 <= cyc;
      if (v0 && !vq0) rc0 <= cyc;
      if (clr) begin
         ac0 <= 0; ac1 <= 0; ov_n <= 0; tk0 <= 0; cap_n <= 0;
      end else begin
         if (al0) ac0 <= ac0 + 1;
         if (al1) ac1 <= ac1 + 1;
         if (ov0 || ov1) ov_n <= ov_n + 1;
         if (tick0) tk0 <= tk0 + 1;
         if (v0 && rdy0 && cap_n < 4) begin
            cap[cap_n] <= d0;
            cap_n      <= cap_n + 1;
         end
      end
   end

   int n_vec = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic drv(input logic s, input logic b, input int n);
      if (s) rx1 = b; else rx0 = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input logic s, input logic [7:0] d, input logic p, input logic stop);
      drv(s, 1'b0, 16);
      for (int i = 0; i < 8; i++) drv(s, d[i], 16);
      if (s) drv(s, p, 16);
      drv(s, stop, 16);
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 40 && !sv; k++) @(negedge clk);
   endtask

   typedef struct {
      logic       sel;
      logic [7:0] d;
      logic       par;
      logic       stop;
      int         tail;
      logic [7:0] exp_d;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;
   vec_t vt [7];

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0};
      vt[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 40, 8'h3C, 1'b1, 1'b0};
      vt[2] = '{1'b0, 8'h5A, 1'b0, 1'b1, 0,  8'h5A, 1'b0, 1'b0};
      vt[3] = '{1'b1, 8'h07, 1'b1, 1'b1, 0,  8'h07, 1'b0, 1'b0};
      vt[4] = '{1'b1, 8'h07, 1'b0, 1'b1, 0,  8'h07, 1'b0, 1'b1};
      vt[5] = '{1'b1, 8'h80, 1'b1, 1'b1, 0,  8'h80, 1'b0, 1'b0};
      vt[6] = '{1'b1, 8'hE3, 1'b0, 1'b0, 20, 8'hE3, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset dut0", {en0, al0, v0, fe0, pe0, ov0, bz0, d0}, 0);
      chk("reset dut1", {en1, al1, v1, fe1, pe1, ov1, bz1, d1}, 0);
      rst_n = 1'b1;
      drv(0, 1'b1, 10);

      for (int i = 0; i < 7; i++) begin
         sel = vt[i].sel;
         clear();
         frame(sel, vt[i].d, vt[i].par, vt[i].stop);
         drv(sel, vt[i].stop, vt[i].tail);
         chk($sformatf("v%0d busy after frame", i), sbz, 0);
         wait_valid();
         chk($sformatf("v%0d valid", i), sv, 1);
         chk($sformatf("v%0d data", i), sd, vt[i].exp_d);
         chk($sformatf("v%0d frame_err", i), sfe, vt[i].exp_fe);
         chk($sformatf("v%0d parity_err", i), spe, vt[i].exp_pe);
         chk($sformatf("v%0d align pulses", i), sel ? ac1 : ac0, 1);
         if (!sel) begin
            chk($sformatf("v%0d ticks", i), tk0, 10);
            chk($sformatf("v%0d valid latency", i), rc0, lt0 + 1);
         end
         drv(sel, 1'b1, 4);
         chk($sformatf("v%0d valid held", i), sv, 1);
         if (sel) rdy1 = 1'b1; else rdy0 = 1'b1;
         @(negedge clk);
         rdy0 = 1'b0;
         rdy1 = 1'b0;
         chk($sformatf("v%0d valid cleared", i), sv, 0);
         drv(sel, 1'b1, 20);
      end
      sel = 1'b0;

      clear();
      drv(0, 1'b0, 4);
      drv(0, 1'b1, 30);
      chk("glitch align", ac0, 1);
      chk("glitch ticks", tk0, 1);
      chk("glitch baud_en", en0, 0);
      chk("glitch busy", bz0, 0);
      chk("glitch valid", v0, 0);

      clear();
      rdy0 = 1'b1;
      frame(0, 8'h00, 1'b0, 1'b1);
      frame(0, 8'hFF, 1'b0, 1'b1);
      frame(0, 8'h55, 1'b0, 1'b1);
      drv(0, 1'b1, 20);
      rdy0 = 1'b0;
      chk("b2b count", cap_n, 3);
      chk("b2b word0", cap[0], 8'h00);
      chk("b2b word1", cap[1], 8'hFF);
      chk("b2b word2", cap[2], 8'h55);
      chk("b2b overrun", ov_n, 0);

      clear();
      frame(0, 8'h11, 1'b0, 1'b1);
      frame(0, 8'h22, 1'b0, 1'b1);
      drv(0, 1'b1, 10);
      chk("ovr pulses", ov_n, 1);
      chk("ovr valid", v0, 1);
      chk("ovr data", d0, 8'h11);
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
      chk("ovr valid cleared", v0, 0);

      drv(0, 1'b0, 16);
      drv(0, 1'b1, 16);
      drv(0, 1'b0, 8);
      chk("mid-frame busy", bz0, 1);
      #2 rst_n = 1'b0;
      #1 chk("async reset dut0", {en0, al0, v0, fe0, pe0, ov0, bz0, d0}, 0);
      rx0 = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drv(0, 1'b1, 20);
      clear();
      frame(0, 8'h96, 1'b0, 1'b1);
      wait_valid();
      chk("post-reset valid", v0, 1);
      chk("post-reset data", d0, 8'h96);
      chk("post-reset frame_err", fe0, 0);
      chk("post-reset align", ac0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
